mm_tile_sched: RTL and testbench
================================

# mm_tile_sched

Tile-loop scheduler for the T×T matrix-multiply array. It sits directly downstream of the host register block and consumes its configuration fields: base addresses, N, leading dimensions, start and irq enable. It walks the output-tile / K-tile loop nest and emits one command per A-tile load, B-tile load and C-tile store to the DMA/tile-buffer stage. It reports done, error and interrupt back to the register block.

## Interface

Parameters:
- T, 16, tile edge (elements); array is T×T
- W, 8, element width in bits; element byte size EB = W/8
- ACCW, 32, accumulator width in bits; C element byte size CB = ACCW/8

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  launch pulse; sampled only in IDLE
- base_a, base_b, base_c  in  32 each  byte base addresses
- n  in  16  matrix dimension (elements)
- lda, ldb, ldc  in  16 each  leading dimensions (elements)
- irq_en  in  1  interrupt enable
- irq_clr  in  1  clears sticky irq
- cmd_valid  out  1  command valid
- cmd_ready  in  1  consumer accepts command
- cmd_kind  out  2  0 = LOAD_A, 1 = LOAD_B, 2 = STORE_C
- cmd_addr  out  32  byte address of tile element [0][0]
- cmd_stride  out  32  byte stride between tile rows
- cmd_first_k  out  1  first K-tile of this output tile (array clears accumulators)
- cmd_last_k  out  1  last K-tile of this output tile
- busy  out  1  high from accepted start until done pulse
- done  out  1  one-cycle completion pulse
- err  out  1  sticky config error; cleared on next accepted start
- irq  out  1  sticky interrupt

## Operation

- Config (base_*, n, ld*, irq_en) is latched on the accepted start; inputs may change afterwards without effect.
- Tile count: tiles = n/T.
- Config error: n == 0 or n mod T ≠ 0. On error, no commands are issued, err is set, and done pulses.
- Loop nest: ti = 0..tiles-1 outer, tj = 0..tiles-1, tk = 0..tiles-1 inner.
- Per tk, issue LOAD_A then LOAD_B:
  - A addr = base_a + (ti·T·lda + tk·T)·EB, stride = lda·EB
  - B addr = base_b + (tk·T·ldb + tj·T)·EB, stride = ldb·EB
- cmd_first_k = (tk == 0) and cmd_last_k = (tk == tiles-1) on both loads.
- After the tk = tiles-1 LOAD_B, issue STORE_C:
  - addr = base_c + (ti·T·ldc + tj·T)·CB, stride = ldc·CB
  - first_k = last_k = 0
- All address arithmetic is modulo 2^32, unsigned. Incremental pointer updates are allowed; results must equal the formulas.
- Total commands = tiles²·(2·tiles + 1).
- FSM states: IDLE, CHECK, LOAD_A, LOAD_B, STORE_C, FIN.
  - IDLE --start--> CHECK
  - CHECK --err--> FIN
  - CHECK --ok--> LOAD_A
  - LOAD_A --hs--> LOAD_B
  - LOAD_B --hs, tk < last--> LOAD_A (tk+1)
  - LOAD_B --hs, tk last--> STORE_C
  - STORE_C --hs, more tiles--> LOAD_A (tk = 0, next tj, or next ti with tj = 0)
  - STORE_C --hs, final tile--> FIN
  - FIN --> IDLE
- "hs" = cmd_valid & cmd_ready.
- irq is set in FIN when latched irq_en = 1 and stays set until irq_clr. If irq_clr and the set condition coincide, set wins.

## Timing

- Reset: state IDLE. cmd_valid, cmd_kind, cmd_addr, cmd_stride, cmd_first_k, cmd_last_k, busy, done, err and irq all 0. Loop counters are 0.
- Reset mid-run aborts immediately: any pending command is dropped and no done pulse is produced.
- start is accepted in IDLE only; start while busy is ignored. busy rises the cycle after start.
- The first cmd_valid is asserted 2 cycles after start (CHECK takes 1 cycle).
- Valid/ready rules:
  - cmd_valid does not depend combinationally on cmd_ready.
  - Once cmd_valid is high, all cmd_* fields stay stable until the handshake.
  - The next command is presented the cycle after a handshake; at full throughput this is one command per cycle.
- done pulses in FIN, one cycle after the final STORE_C handshake, or 2 cycles after start on error. busy falls together with done.
- err and irq update in the same cycle as done.

## Test plan

- n=16, lda=ldb=ldc=16, base_a=0x1000, base_b=0x2000, base_c=0x3000, cmd_ready=1 -> exactly 3 commands:
  - A @0x1000 stride 16, first=last=1
  - B @0x2000 stride 16, first=last=1
  - C @0x3000 stride 64
  - done 1 cycle after the C handshake.
- n=32, ld*=32, same bases, ready=1 -> 20 commands in loop order. Spot checks:
  - (ti=0, tj=0, tk=1): A @0x1010, B @0x2200
  - (ti=1, tj=1): C @0x3840
- Random cmd_ready backpressure on the n=32 run -> cmd_* held stable while valid & !ready; command sequence identical to the no-backpressure run.
- n=20 (and n=0) -> no cmd_valid; err=1 and done pulse 2 cycles after start; next valid start clears err.
- Reset asserted after the 5th handshake of the n=32 run -> all outputs 0 the next cycle; a fresh start reproduces the full 20-command sequence.
- irq_en=1 run -> irq set with done and held; irq_clr clears it. Same run with irq_en=0 -> irq stays 0. Start pulsed while busy -> ignored, sequence unchanged.

Source files
------------

// File: rtl/mm_tile_sched.sv
// mm_tile_sched: walks the output-tile / K-tile loop nest of a T x T
// matrix-multiply array and emits one LOAD_A, LOAD_B or STORE_C command per
// tile to the DMA/tile-buffer stage. Addresses are kept as running pointers
// that always equal the closed-form tile address formulas.
module mm_tile_sched #(
    parameter int T    = 16,
    parameter int W    = 8,
    parameter int ACCW = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_a,
    input  logic [31:0] base_b,
    input  logic [31:0] base_c,
    input  logic [15:0] n,
    input  logic [15:0] lda,
    input  logic [15:0] ldb,
    input  logic [15:0] ldc,
    input  logic        irq_en,
    input  logic        irq_clr,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_kind,
    output logic [31:0] cmd_addr,
    output logic [31:0] cmd_stride,
    output logic        cmd_first_k,
    output logic        cmd_last_k,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        irq
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_LOAD_A  = 3'd2;
    localparam logic [2:0] S_LOAD_B  = 3'd3;
    localparam logic [2:0] S_STORE_C = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    localparam logic [1:0] KIND_A = 2'd0;
    localparam logic [1:0] KIND_B = 2'd1;
    localparam logic [1:0] KIND_C = 2'd2;

    localparam logic [31:0] EB  = 32'(W / 8);
    localparam logic [31:0] CB  = 32'(ACCW / 8);
    localparam logic [31:0] TEB = 32'(T * (W / 8));
    localparam logic [31:0] TCB = 32'(T * (ACCW / 8));
    localparam logic [15:0] T16 = 16'(T);

    logic [2:0]  state_r;
    logic [15:0] ti_r, tj_r, tk_r, tiles_r, n_r;
    logic [15:0] lda_r, ldb_r, ldc_r;
    logic [31:0] base_a_r, base_b_r, base_c_r;
    logic        irq_en_r;
    // a_row: A tile at (ti, tk=0); b_col: B tile at (tk=0, tj); c_row: C tile at (ti, tj=0)
    logic [31:0] a_row_r, a_ptr_r, b_col_r, b_ptr_r, c_row_r, c_ptr_r;
    logic        cmd_valid_r, cmd_first_k_r, cmd_last_k_r;
    logic [1:0]  cmd_kind_r;
    logic [31:0] cmd_addr_r, cmd_stride_r;
    logic        busy_r, done_r, err_r, irq_r;

    logic        hs_s, cfg_bad_s, tk_last_s, tj_last_s, ti_last_s, fin_entry_s;
    logic [31:0] stride_a_s, stride_b_s, stride_c_s;
    logic [31:0] a_row_nxt_s, a_ptr_nxt_s, b_ptr_nxt_s, b_col_nxt_s, c_row_nxt_s, c_ptr_nxt_s;

    // Handshake, loop-end flags, strides and next pointer values.
    always_comb begin
        hs_s        = cmd_valid_r & cmd_ready;
        cfg_bad_s   = (n_r == 16'd0) || ((n_r % T16) != 16'd0);
        tk_last_s   = (tk_r == (tiles_r - 16'd1));
        tj_last_s   = (tj_r == (tiles_r - 16'd1));
        ti_last_s   = (ti_r == (tiles_r - 16'd1));
        stride_a_s  = 32'(lda_r) * EB;
        stride_b_s  = 32'(ldb_r) * EB;
        stride_c_s  = 32'(ldc_r) * CB;
        a_row_nxt_s = a_row_r + 32'(lda_r) * TEB;
        a_ptr_nxt_s = a_ptr_r + TEB;
        b_ptr_nxt_s = b_ptr_r + 32'(ldb_r) * TEB;
        b_col_nxt_s = b_col_r + TEB;
        c_row_nxt_s = c_row_r + 32'(ldc_r) * TCB;
        c_ptr_nxt_s = c_ptr_r + TCB;
        if (state_r == S_CHECK) begin
            fin_entry_s = cfg_bad_s;
        end else if (state_r == S_STORE_C) begin
            fin_entry_s = hs_s & tj_last_s & ti_last_s;
        end else begin
            fin_entry_s = 1'b0;
        end
    end

    // Sticky interrupt: set on entry to FIN when enabled; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_r <= 1'b0;
        end else if (fin_entry_s && irq_en_r) begin
            irq_r <= 1'b1;
        end else if (irq_clr) begin
            irq_r <= 1'b0;
        end
    end

    // Loop-nest FSM, config latch, pointer updates and registered command outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            ti_r          <= 16'd0;
            tj_r          <= 16'd0;
            tk_r          <= 16'd0;
            tiles_r       <= 16'd0;
            n_r           <= 16'd0;
            lda_r         <= 16'd0;
            ldb_r         <= 16'd0;
            ldc_r         <= 16'd0;
            base_a_r      <= 32'd0;
            base_b_r      <= 32'd0;
            base_c_r      <= 32'd0;
            irq_en_r      <= 1'b0;
            a_row_r       <= 32'd0;
            a_ptr_r       <= 32'd0;
            b_col_r       <= 32'd0;
            b_ptr_r       <= 32'd0;
            c_row_r       <= 32'd0;
            c_ptr_r       <= 32'd0;
            cmd_valid_r   <= 1'b0;
            cmd_kind_r    <= 2'd0;
            cmd_addr_r    <= 32'd0;
            cmd_stride_r  <= 32'd0;
            cmd_first_k_r <= 1'b0;
            cmd_last_k_r  <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        base_a_r <= base_a;
                        base_b_r <= base_b;
                        base_c_r <= base_c;
                        n_r      <= n;
                        tiles_r  <= n / T16;
                        lda_r    <= lda;
                        ldb_r    <= ldb;
                        ldc_r    <= ldc;
                        irq_en_r <= irq_en;
                        ti_r     <= 16'd0;
                        tj_r     <= 16'd0;
                        tk_r     <= 16'd0;
                        busy_r   <= 1'b1;
                        err_r    <= 1'b0;
                        state_r  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    a_row_r <= base_a_r;
                    a_ptr_r <= base_a_r;
                    b_col_r <= base_b_r;
                    b_ptr_r <= base_b_r;
                    c_row_r <= base_c_r;
                    c_ptr_r <= base_c_r;
                    if (cfg_bad_s) begin
                        err_r   <= 1'b1;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= S_FIN;
                    end else begin
                        cmd_valid_r   <= 1'b1;
                        cmd_kind_r    <= KIND_A;
                        cmd_addr_r    <= base_a_r;
                        cmd_stride_r  <= stride_a_s;
                        cmd_first_k_r <= 1'b1;
                        cmd_last_k_r  <= (tiles_r == 16'd1);
                        state_r       <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    if (hs_s) begin
                        cmd_kind_r   <= KIND_B;
                        cmd_addr_r   <= b_ptr_r;
                        cmd_stride_r <= stride_b_s;
                        state_r      <= S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    if (hs_s) begin
                        if (!tk_last_s) begin
                            tk_r          <= tk_r + 16'd1;
                            a_ptr_r       <= a_ptr_nxt_s;
                            b_ptr_r       <= b_ptr_nxt_s;
                            cmd_kind_r    <= KIND_A;
                            cmd_addr_r    <= a_ptr_nxt_s;
                            cmd_stride_r  <= stride_a_s;
                            cmd_first_k_r <= 1'b0;
                            cmd_last_k_r  <= ((tk_r + 16'd1) == (tiles_r - 16'd1));
                            state_r       <= S_LOAD_A;
                        end else begin
                            cmd_kind_r    <= KIND_C;
                            cmd_addr_r    <= c_ptr_r;
                            cmd_stride_r  <= stride_c_s;
                            cmd_first_k_r <= 1'b0;
                            cmd_last_k_r  <= 1'b0;
                            state_r       <= S_STORE_C;
                        end
                    end
                end
                S_STORE_C: begin
                    if (hs_s) begin
                        if (tj_last_s && ti_last_s) begin
                            cmd_valid_r <= 1'b0;
                            done_r      <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= S_FIN;
                        end else begin
                            tk_r          <= 16'd0;
                            cmd_kind_r    <= KIND_A;
                            cmd_stride_r  <= stride_a_s;
                            cmd_first_k_r <= 1'b1;
                            cmd_last_k_r  <= (tiles_r == 16'd1);
                            state_r       <= S_LOAD_A;
                            if (tj_last_s) begin
                                tj_r       <= 16'd0;
                                ti_r       <= ti_r + 16'd1;
                                a_row_r    <= a_row_nxt_s;
                                a_ptr_r    <= a_row_nxt_s;
                                b_col_r    <= base_b_r;
                                b_ptr_r    <= base_b_r;
                                c_row_r    <= c_row_nxt_s;
                                c_ptr_r    <= c_row_nxt_s;
                                cmd_addr_r <= a_row_nxt_s;
                            end else begin
                                tj_r       <= tj_r + 16'd1;
                                a_ptr_r    <= a_row_r;
                                b_col_r    <= b_col_nxt_s;
                                b_ptr_r    <= b_col_nxt_s;
                                c_ptr_r    <= c_ptr_nxt_s;
                                cmd_addr_r <= a_row_r;
                            end
                        end
                    end
                end
                S_FIN: begin
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    cmd_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_valid   = cmd_valid_r;
    assign cmd_kind    = cmd_kind_r;
    assign cmd_addr    = cmd_addr_r;
    assign cmd_stride  = cmd_stride_r;
    assign cmd_first_k = cmd_first_k_r;
    assign cmd_last_k  = cmd_last_k_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign irq         = irq_r;

endmodule

// File: tb/tb_mm_tile_sched.sv
// Directed bench for mm_tile_sched: builds the expected command list from the
// closed-form tile address formulas and compares the handshaked commands.
module tb_mm_tile_sched;

    logic        clk = 1'b0;
    logic        rst, start, irq_en, irq_clr, cmd_ready;
    logic [31:0] base_a, base_b, base_c;
    logic [15:0] n, lda, ldb, ldc;
    logic        cmd_valid, cmd_first_k, cmd_last_k, busy, done, err, irq;
    logic [1:0]  cmd_kind;
    logic [31:0] cmd_addr, cmd_stride;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_addr[$], exp_stride[$], exp_flags[$];
    logic [31:0] got_addr[$], got_stride[$], got_flags[$];

    bit g_bp, g_irqen, g_clr, g_busy_start;
    int g_abort;

    always #5 clk = ~clk;

    mm_tile_sched #(.T(16), .W(8), .ACCW(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .n(n), .lda(lda), .ldb(ldb), .ldc(ldc),
        .irq_en(irq_en), .irq_clr(irq_clr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_addr(cmd_addr), .cmd_stride(cmd_stride),
        .cmd_first_k(cmd_first_k), .cmd_last_k(cmd_last_k),
        .busy(busy), .done(done), .err(err), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] flags_of(input logic [1:0] k, input logic f, input logic l);
        return {28'd0, k, f, l};
    endfunction

    // Expected command list from the address formulas (bases 0x1000/0x2000/0x3000).
    task automatic build_exp(input int nn, input int la, input int lb, input int lc);
        int tiles;
        exp_addr.delete(); exp_stride.delete(); exp_flags.delete();
        if (nn == 0 || (nn % 16) != 0) return;
        tiles = nn / 16;
        for (int ti = 0; ti < tiles; ti++)
            for (int tj = 0; tj < tiles; tj++) begin
                for (int tk = 0; tk < tiles; tk++) begin
                    exp_addr.push_back(32'h1000 + 32'(ti * 16 * la + tk * 16));
                    exp_stride.push_back(32'(la));
                    exp_flags.push_back(flags_of(2'd0, tk == 0, tk == tiles - 1));
                    exp_addr.push_back(32'h2000 + 32'(tk * 16 * lb + tj * 16));
                    exp_stride.push_back(32'(lb));
                    exp_flags.push_back(flags_of(2'd1, tk == 0, tk == tiles - 1));
                end
                exp_addr.push_back(32'h3000 + 32'((ti * 16 * lc + tj * 16) * 4));
                exp_stride.push_back(32'(lc * 4));
                exp_flags.push_back(flags_of(2'd2, 1'b0, 1'b0));
            end
    endtask

    task automatic cmp_seq();
        check("cmd_count", 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check($sformatf("addr[%0d]", i), got_addr[i], exp_addr[i]);
            check($sformatf("stride[%0d]", i), got_stride[i], exp_stride[i]);
            check($sformatf("flags[%0d]", i), got_flags[i], exp_flags[i]);
        end
    endtask

    task automatic run_job(input logic [15:0] nn, input logic [15:0] la,
                           input logic [15:0] lb, input logic [15:0] lc);
        int cyc, last_hs;
        bit stalled, finished, cfg_bad;
        logic [31:0] h_addr, h_stride, h_flags;
        cfg_bad = (nn == 16'd0) || ((nn % 16'd16) != 16'd0);
        build_exp(int'(nn), int'(la), int'(lb), int'(lc));
        got_addr.delete(); got_stride.delete(); got_flags.delete();
        @(negedge clk);
        start = 1'b1; base_a = 32'h1000; base_b = 32'h2000; base_c = 32'h3000;
        n = nn; lda = la; ldb = lb; ldc = lc; irq_en = g_irqen; irq_clr = g_clr; cmd_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; base_a = 32'hdead0000; base_b = 32'hbeef0000; base_c = 32'hcafe0000;
        n = 16'd48; lda = 16'd7; ldb = 16'd9; ldc = 16'd11; irq_en = ~g_irqen;
        check("busy_rise", 32'(busy), 32'd1);
        check("err_clear_on_start", 32'(err), 32'd0);
        check("no_valid_in_check", 32'(cmd_valid), 32'd0);
        cyc = 1; last_hs = 0; stalled = 1'b0; finished = 1'b0;
        h_addr = 32'd0; h_stride = 32'd0; h_flags = 32'd0;
        while (!finished && cyc < 3000) begin
            cmd_ready = g_bp ? 1'($urandom_range(1, 0)) : 1'b1;
            start = g_busy_start && (cyc == 6);
            if (cyc == 2) check("first_valid_time", 32'(cmd_valid), cfg_bad ? 32'd0 : 32'd1);
            if (stalled) begin
                check("hold_valid", 32'(cmd_valid), 32'd1);
                check("hold_addr", cmd_addr, h_addr);
                check("hold_stride", cmd_stride, h_stride);
                check("hold_flags", flags_of(cmd_kind, cmd_first_k, cmd_last_k), h_flags);
            end
            if (cmd_valid) begin
                if (cmd_ready) begin
                    got_addr.push_back(cmd_addr);
                    got_stride.push_back(cmd_stride);
                    got_flags.push_back(flags_of(cmd_kind, cmd_first_k, cmd_last_k));
                    last_hs = cyc;
                    stalled = 1'b0;
                    if (got_addr.size() == g_abort) begin
                        @(negedge clk);
                        return;
                    end
                end else begin
                    stalled  = 1'b1;
                    h_addr   = cmd_addr;
                    h_stride = cmd_stride;
                    h_flags  = flags_of(cmd_kind, cmd_first_k, cmd_last_k);
                end
            end else begin
                stalled = 1'b0;
            end
            if (done) begin
                finished = 1'b1;
                check("done_time", 32'(cyc), cfg_bad ? 32'd2 : 32'(last_hs + 1));
                check("busy_at_done", 32'(busy), 32'd0);
                check("err_at_done", 32'(err), 32'(cfg_bad));
                check("irq_at_done", 32'(irq), 32'(g_irqen));
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("job_finished", 32'(finished), 32'd1);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("err_hold", 32'(err), 32'(cfg_bad));
        check("irq_after_done", 32'(irq), 32'(g_irqen && !g_clr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, "_kind"}, 32'(cmd_kind), 32'd0);
        check({tag, "_addr"}, cmd_addr, 32'd0);
        check({tag, "_stride"}, cmd_stride, 32'd0);
        check({tag, "_fk_lk"}, {30'd0, cmd_first_k, cmd_last_k}, 32'd0);
        check({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_err_irq"}, {30'd0, err, irq}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; irq_en = 1'b0; irq_clr = 1'b0; cmd_ready = 1'b0;
        base_a = 32'd0; base_b = 32'd0; base_c = 32'd0;
        n = 16'd0; lda = 16'd0; ldb = 16'd0; ldc = 16'd0;
        g_bp = 1'b0; g_irqen = 1'b0; g_clr = 1'b0; g_busy_start = 1'b0; g_abort = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // single tile
        run_job(16'd16, 16'd16, 16'd16, 16'd16);
        cmp_seq();
        check("t1_a_addr", got_addr.size() > 0 ? got_addr[0] : 32'hffffffff, 32'h1000);
        check("t1_a_stride", got_stride.size() > 0 ? got_stride[0] : 32'hffffffff, 32'd16);
        check("t1_a_flags", got_flags.size() > 0 ? got_flags[0] : 32'hffffffff, 32'h3);
        check("t1_b_addr", got_addr.size() > 1 ? got_addr[1] : 32'hffffffff, 32'h2000);
        check("t1_b_flags", got_flags.size() > 1 ? got_flags[1] : 32'hffffffff, 32'h7);
        check("t1_c_addr", got_addr.size() > 2 ? got_addr[2] : 32'hffffffff, 32'h3000);
        check("t1_c_stride", got_stride.size() > 2 ? got_stride[2] : 32'hffffffff, 32'd64);
        check("t1_c_flags", got_flags.size() > 2 ? got_flags[2] : 32'hffffffff, 32'h8);

        // 2x2 tiles, full throughput, start pulsed while busy
        g_busy_start = 1'b1;
        run_job(16'd32, 16'd32, 16'd32, 16'd32);
        g_busy_start = 1'b0;
        cmp_seq();
        check("t2_a_k1", got_addr.size() > 2 ? got_addr[2] : 32'hffffffff, 32'h1010);
        check("t2_b_k1", got_addr.size() > 3 ? got_addr[3] : 32'hffffffff, 32'h2200);
        check("t2_c_11", got_addr.size() > 19 ? got_addr[19] : 32'hffffffff, 32'h3840);

        // random backpressure, then distinct leading dimensions
        g_bp = 1'b1;
        run_job(16'd32, 16'd32, 16'd32, 16'd32);
        cmp_seq();
        run_job(16'd48, 16'd40, 16'd48, 16'd64);
        cmp_seq();
        g_bp = 1'b0;

        // config errors, then a valid start clears err
        run_job(16'd20, 16'd32, 16'd32, 16'd32);
        cmp_seq();
        run_job(16'd0, 16'd32, 16'd32, 16'd32);
        cmp_seq();
        run_job(16'd16, 16'd16, 16'd16, 16'd16);
        cmp_seq();

        // reset after the 5th handshake, then a full rerun
        g_abort = 5;
        run_job(16'd32, 16'd32, 16'd32, 16'd32);
        g_abort = 0;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        run_job(16'd32, 16'd32, 16'd32, 16'd32);
        cmp_seq();

        // irq set, held, then cleared
        g_irqen = 1'b1;
        run_job(16'd16, 16'd16, 16'd16, 16'd16);
        repeat (3) @(negedge clk);
        check("irq_held", 32'(irq), 32'd1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("irq_cleared", 32'(irq), 32'd0);

        // irq_clr held through the set: set wins, then clears
        g_clr = 1'b1;
        run_job(16'd16, 16'd16, 16'd16, 16'd16);
        g_clr = 1'b0;
        irq_clr = 1'b0;

        // irq disabled
        g_irqen = 1'b0;
        run_job(16'd32, 16'd32, 16'd32, 16'd32);
        cmp_seq();
        repeat (2) @(negedge clk);
        check("irq_stays_low", 32'(irq), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
